// File: rtl/scan_mux_pkg.sv
// Shared constants for the scan_mux slice: mode encoding and a counter-width helper.
package scan_mux_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_mux_if.sv
// Output stream of scan_mux: one registered beat with a valid/ready handshake.
interface scan_mux_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SW = $clog2(N_CH);

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SW-1:0]    out_ch;

  modport master (output out_valid, output out_data, output out_ch, input out_ready);
  modport slave  (input out_valid, input out_data, input out_ch, output out_ready);
endinterface

// File: rtl/scan_mux_rr_next_idx.sv
// Combinational round-robin search: first set mask bit strictly after cur, wrapping.
// With only cur set, the search wraps all the way round and returns cur itself.
module rr_next_idx #(
  parameter  int N_CH = 4,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [SW-1:0]   cur,
  output logic [SW-1:0]   nxt,
  output logic            any
);

  int idx;

  always_comb begin
    nxt = cur;
    any = |mask;
    idx = 0;
    // Walk from farthest to nearest so the nearest hit is the one left standing.
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(cur) + k) % N_CH;
      if (mask[idx[SW-1:0]]) begin
        nxt = idx[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// N-channel registered mux with valid/ready output; STATIC select or round-robin SCAN
// over enabled channels, DWELL beats per channel.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  parameter  int DWELL = 4,
  localparam int SW    = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] ch_data,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  mode,
  input  logic [SW-1:0]         sel_in,
  scan_mux_if.master            bus
);

  localparam int DW = cnt_width(DWELL);

  logic [WIDTH-1:0] ch_word [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_word
      assign ch_word[gi] = ch_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg,  out_data_next;
  logic [SW-1:0]    out_ch_reg,    out_ch_next;
  logic [SW-1:0]    cur_ch_reg,    cur_ch_next;
  logic [DW-1:0]    dwell_cnt_reg, dwell_cnt_next;
  logic             mode_reg,      mode_next;

  logic             load, mode_change, entering_scan, sel_ok, src_en, rr_any;
  logic [SW-1:0]    start_ch, scan_ch, src_ch, rr_nxt;
  logic [WIDTH-1:0] src_data;
  logic [DW-1:0]    dwell_base;

  rr_next_idx #(.N_CH(N_CH)) u_rr (
    .mask (ch_en),
    .cur  (scan_ch),
    .nxt  (rr_nxt),
    .any  (rr_any)
  );

  always_comb begin
    load          = !out_valid_reg || bus.out_ready;
    mode_change   = (mode != mode_reg);
    entering_scan = mode_change && (mode == MODE_SCAN);
    sel_ok        = (int'(sel_in) < N_CH);
    start_ch      = sel_ok ? sel_in : '0;
    // The scan pointer takes its starting channel in the same cycle SCAN is entered.
    scan_ch       = entering_scan ? start_ch : cur_ch_reg;
    dwell_base    = mode_change ? '0 : dwell_cnt_reg;

    if (mode == MODE_SCAN) begin
      src_ch   = scan_ch;
      src_en   = ch_en[scan_ch];
      src_data = ch_word[scan_ch];
    end else begin
      src_ch   = sel_in;
      src_en   = sel_ok && ch_en[sel_in];
      src_data = sel_ok ? ch_word[sel_in] : '0;
    end

    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    cur_ch_next    = (mode == MODE_SCAN) ? scan_ch : cur_ch_reg;
    dwell_cnt_next = dwell_base;
    mode_next      = mode;

    if (load) begin
      out_valid_next = src_en;
      out_data_next  = src_data;
      out_ch_next    = src_ch;
    end

    // Dwell is counted as valid beats enter the register; every such beat is
    // later accepted, so this equals the accepted-beat count per channel.
    if ((mode == MODE_SCAN) && rr_any) begin
      if (!ch_en[scan_ch]) begin
        cur_ch_next    = rr_nxt;
        dwell_cnt_next = '0;
      end else if (load) begin
        if (dwell_base == DW'(DWELL - 1)) begin
          cur_ch_next    = rr_nxt;
          dwell_cnt_next = '0;
        end else begin
          dwell_cnt_next = dwell_base + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      cur_ch_reg    <= '0;
      dwell_cnt_reg <= '0;
      mode_reg      <= MODE_STATIC;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      cur_ch_reg    <= cur_ch_next;
      dwell_cnt_reg <= dwell_cnt_next;
      mode_reg      <= mode_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;

endmodule
